// File: rtl/text_console_writer.sv
// Text console writer: turns a stream of ASCII codes into single-cell character-buffer
// writes, tracking a cursor, interpreting control codes and running hardware clear sweeps.
module text_console_writer #(
  parameter int unsigned SCOLS = 80,
  parameter int unsigned SROWS = 60,
  parameter int unsigned LCOLS = 40,
  parameter int unsigned LROWS = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sL,
  input  logic       char_valid,
  output logic       char_ready,
  input  logic [6:0] char_ascii,
  input  logic [5:0] char_colour,
  input  logic       char_hl,
  output logic       wr_en,
  output logic [6:0] wr_x,
  output logic [5:0] wr_y,
  output logic [6:0] wr_ascii,
  output logic [5:0] wr_colour,
  output logic       wr_hl,
  output logic [6:0] cursor_x,
  output logic [5:0] cursor_y,
  output logic       busy
);

  localparam logic [6:0] Blank = 7'h20;

  typedef enum logic [1:0] {StIdle, StClrAll, StClrRow} state_e;

  state_e     state_q;
  logic       sl_q;
  logic [6:0] sweep_x_q;
  logic [5:0] sweep_y_q;
  logic [6:0] last_col;
  logic [5:0] last_row;
  logic [5:0] next_row;
  logic       take;
  logic       printable;

  always_comb begin
    last_col = sL ? 7'(LCOLS - 1) : 7'(SCOLS - 1);
    last_row = sL ? 6'(LROWS - 1) : 6'(SROWS - 1);
    next_row = (cursor_y == last_row) ? 6'd0 : cursor_y + 6'd1;
  end

  assign char_ready = (state_q == StIdle) && (sL == sl_q);
  assign busy       = (state_q != StIdle);
  assign take       = char_valid && char_ready;
  assign printable  = (char_ascii >= 7'h20) && (char_ascii <= 7'h7e);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StClrAll;
      sl_q      <= sL;
      sweep_x_q <= '0;
      sweep_y_q <= '0;
      cursor_x  <= '0;
      cursor_y  <= '0;
      wr_en     <= 1'b0;
      wr_x      <= '0;
      wr_y      <= '0;
      wr_ascii  <= '0;
      wr_colour <= '0;
      wr_hl     <= 1'b0;
    end else begin
      sl_q  <= sL;
      wr_en <= 1'b0;
      if (sL != sl_q) begin
        // Grid change wins over everything: restart a full sweep on the new geometry
        state_q   <= StClrAll;
        sweep_x_q <= '0;
        sweep_y_q <= '0;
        cursor_x  <= '0;
        cursor_y  <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (take) begin
              if (printable) begin
                wr_en     <= 1'b1;
                wr_x      <= cursor_x;
                wr_y      <= cursor_y;
                wr_ascii  <= char_ascii;
                wr_colour <= char_colour;
                wr_hl     <= char_hl;
                if (cursor_x == last_col) begin
                  cursor_x  <= '0;
                  cursor_y  <= next_row;
                  sweep_x_q <= '0;
                  state_q   <= StClrRow;
                end else begin
                  cursor_x <= cursor_x + 7'd1;
                end
              end else begin
                case (char_ascii)
                  7'h0a: begin
                    cursor_x  <= '0;
                    cursor_y  <= next_row;
                    sweep_x_q <= '0;
                    state_q   <= StClrRow;
                  end
                  7'h0d: cursor_x <= '0;
                  7'h08: begin
                    if (cursor_x != '0) begin
                      cursor_x  <= cursor_x - 7'd1;
                      wr_en     <= 1'b1;
                      wr_x      <= cursor_x - 7'd1;
                      wr_y      <= cursor_y;
                      wr_ascii  <= Blank;
                      wr_colour <= '0;
                      wr_hl     <= 1'b0;
                    end
                  end
                  7'h0c: begin
                    state_q   <= StClrAll;
                    sweep_x_q <= '0;
                    sweep_y_q <= '0;
                    cursor_x  <= '0;
                    cursor_y  <= '0;
                  end
                  default: ;
                endcase
              end
            end
          end
          StClrRow: begin
            wr_en     <= 1'b1;
            wr_x      <= sweep_x_q;
            wr_y      <= cursor_y;
            wr_ascii  <= Blank;
            wr_colour <= '0;
            wr_hl     <= 1'b0;
            if (sweep_x_q == last_col) begin
              sweep_x_q <= '0;
              state_q   <= StIdle;
            end else begin
              sweep_x_q <= sweep_x_q + 7'd1;
            end
          end
          StClrAll: begin
            wr_en     <= 1'b1;
            wr_x      <= sweep_x_q;
            wr_y      <= sweep_y_q;
            wr_ascii  <= Blank;
            wr_colour <= '0;
            wr_hl     <= 1'b0;
            if (sweep_x_q == last_col) begin
              sweep_x_q <= '0;
              if (sweep_y_q == last_row) begin
                sweep_y_q <= '0;
                cursor_x  <= '0;
                cursor_y  <= '0;
                state_q   <= StIdle;
              end else begin
                sweep_y_q <= sweep_y_q + 6'd1;
              end
            end else begin
              sweep_x_q <= sweep_x_q + 7'd1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: a queue of expected per-cycle buffer writes built from the
// console rules, compared against the DUT every cycle, plus literal scenario checks.
module tb_text_console_writer;

  logic       clk = 1'b0;
  logic       reset;
  logic       sL;
  logic       char_valid;
  logic       char_ready;
  logic [6:0] char_ascii;
  logic [5:0] char_colour;
  logic       char_hl;
  logic       wr_en;
  logic [6:0] wr_x;
  logic [5:0] wr_y;
  logic [6:0] wr_ascii;
  logic [5:0] wr_colour;
  logic       wr_hl;
  logic [6:0] cursor_x;
  logic [5:0] cursor_y;
  logic       busy;

  always #5 clk = ~clk;

  text_console_writer dut (
    .clk        (clk),
    .reset      (reset),
    .sL         (sL),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .char_ascii (char_ascii),
    .char_colour(char_colour),
    .char_hl    (char_hl),
    .wr_en      (wr_en),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_ascii   (wr_ascii),
    .wr_colour  (wr_colour),
    .wr_hl      (wr_hl),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .busy       (busy)
  );

  typedef struct packed {
    logic       v;
    logic [6:0] x;
    logic [5:0] y;
    logic [6:0] a;
    logic [5:0] c;
    logic       h;
  } cell_t;

  // Entry 0 is what the DUT must show in the current cycle; v=0 means no write expected.
  cell_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    model_on = 0;
  int    m_cx = 0;
  int    m_cy = 0;
  logic  m_slq = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void push_cell(bit v, int x, int y, int a, int c, int h);
    cell_t e;
    e.v = v;
    e.x = 7'(x);
    e.y = 6'(y);
    e.a = 7'(a);
    e.c = 6'(c);
    e.h = 1'(h);
    exp_q.push_back(e);
  endfunction

  function automatic void push_bubble();
    push_cell(0, 0, 0, 0, 0, 0);
  endfunction

  function automatic void push_row(int y, int cols);
    for (int x = 0; x < cols; x++) push_cell(1, x, y, 32, 0, 0);
  endfunction

  function automatic void push_sweep(int cols, int rows);
    push_bubble();
    for (int y = 0; y < rows; y++) push_row(y, cols);
  endfunction

  function automatic void newline(int cols, int rows);
    m_cx = 0;
    m_cy = (m_cy + 1) % rows;
    push_row(m_cy, cols);
  endfunction

  // Reference model: advances one cycle per edge using the console rules.
  always @(posedge clk) begin
    int cols;
    int rows;
    int code;
    bit rdy;
    cols = sL ? 40 : 80;
    rows = sL ? 30 : 60;
    rdy  = model_on && (exp_q.size() <= 1) && (sL == m_slq);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    if (reset) begin
      exp_q.delete();
      push_sweep(cols, rows);
      m_cx = 0;
      m_cy = 0;
      model_on = 1;
    end else if (model_on && (sL != m_slq)) begin
      exp_q.delete();
      push_sweep(cols, rows);
      m_cx = 0;
      m_cy = 0;
    end else if (char_valid && rdy) begin
      code = int'(char_ascii);
      if (code >= 32 && code <= 126) begin
        push_cell(1, m_cx, m_cy, code, int'(char_colour), int'(char_hl));
        if (m_cx == cols - 1) newline(cols, rows);
        else m_cx++;
      end else if (code == 10) begin
        push_bubble();
        newline(cols, rows);
      end else if (code == 13) begin
        m_cx = 0;
      end else if (code == 8) begin
        if (m_cx > 0) begin
          m_cx--;
          push_cell(1, m_cx, m_cy, 32, 0, 0);
        end
      end else if (code == 12) begin
        exp_q.delete();
        push_sweep(cols, rows);
        m_cx = 0;
        m_cy = 0;
      end
    end
    m_slq = sL;
  end

  always @(negedge clk) begin
    if (model_on) begin
      cell_t e;
      e = '0;
      if (exp_q.size() > 0) e = exp_q[0];
      check("wr_en", 32'(wr_en), 32'(e.v));
      if (e.v) check("wr_cell", {wr_x, wr_y, wr_ascii, wr_colour, wr_hl}, {e.x, e.y, e.a, e.c, e.h});
      check("cursor", {cursor_x, cursor_y}, {7'(m_cx), 6'(m_cy)});
      check("char_ready", 32'(char_ready), 32'((exp_q.size() <= 1) && (sL == m_slq)));
      check("busy", 32'(busy), 32'(exp_q.size() > 1));
    end
  end

  // Present a code and hold it until a handshake edge; returns just after that edge.
  task automatic send(input logic [6:0] code, input logic [5:0] col, input logic hl);
    int n;
    bit rdy;
    n = 0;
    char_valid  = 1'b1;
    char_ascii  = code;
    char_colour = col;
    char_hl     = hl;
    do begin
      @(negedge clk);
      rdy = char_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 10000);
    #1;
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: code %0h not accepted, expected acceptance", code);
    end
    char_valid = 1'b0;
  endtask

  task automatic wait_ready(output int writes, output int low, output logic [12:0] last_xy);
    bit done;
    done    = 0;
    writes  = 0;
    low     = 0;
    last_xy = 13'h1fff;
    for (int i = 0; i < 6000 && !done; i++) begin
      @(negedge clk);
      if (wr_en) writes++;
      if (char_ready) begin
        done = 1;
        if (wr_en) last_xy = {wr_x, wr_y};
      end else begin
        low++;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_ready: char_ready stayed 0, expected 1 within 6000 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic next_write(output logic en, output logic [19:0] xya);
    @(negedge clk);
    en  = wr_en;
    xya = {wr_x, wr_y, wr_ascii};
    @(posedge clk);
    #1;
  endtask

  task automatic goto_xy(input int x, input int y);
    for (int i = 0; i < y; i++) send(7'h0a, 6'd0, 1'b0);
    for (int i = 0; i < x; i++) send(7'($urandom_range(32, 126)), 6'($urandom), 1'($urandom));
  endtask

  initial begin
    int          w;
    int          lo;
    logic [12:0] lxy;
    logic        en;
    logic [19:0] xya;

    reset = 1'b1;
    sL = 1'b0;
    char_valid = 1'b0;
    char_ascii = '0;
    char_colour = '0;
    char_hl = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Power-up sweep, small grid
    wait_ready(w, lo, lxy);
    check("init_writes", w, 4800);
    check("init_last_xy", lxy, {7'd79, 6'd59});
    check("init_cursor", {cursor_x, cursor_y}, 13'd0);

    // Back-to-back printables
    send(7'h41, 6'b110000, 1'b1);
    char_valid = 1'b1;
    char_ascii = 7'h42;
    char_colour = 6'b000011;
    char_hl = 1'b0;
    @(negedge clk);
    check("wr_A", {wr_en, wr_x, wr_y, wr_ascii, wr_colour, wr_hl},
          {1'b1, 7'd0, 6'd0, 7'h41, 6'b110000, 1'b1});
    @(posedge clk);
    #1 char_valid = 1'b0;
    @(negedge clk);
    check("wr_B", {wr_en, wr_x, wr_y, wr_ascii, wr_colour, wr_hl},
          {1'b1, 7'd1, 6'd0, 7'h42, 6'b000011, 1'b0});
    check("cursor_after_AB", {cursor_x, cursor_y}, {7'd2, 6'd0});
    @(posedge clk);
    #1;

    // Large grid, line end at bottom-right corner
    sL = 1'b1;
    wait_ready(w, lo, lxy);
    check("large_writes", w, 1200);
    check("large_last_xy", lxy, {7'd39, 6'd29});
    goto_xy(39, 29);
    check("cursor_39_29", {cursor_x, cursor_y}, {7'd39, 6'd29});
    send(7'h5a, 6'h3f, 1'b0);
    wait_ready(w, lo, lxy);
    check("lineend_writes", w, 41);
    check("lineend_ready_low", lo, 40);
    check("lineend_cursor", {cursor_x, cursor_y}, 13'd0);

    // Control codes, small grid
    sL = 1'b0;
    wait_ready(w, lo, lxy);
    check("small_writes", w, 4800);
    goto_xy(5, 3);
    check("cursor_5_3", {cursor_x, cursor_y}, {7'd5, 6'd3});
    send(7'h08, 6'h15, 1'b1);
    next_write(en, xya);
    check("bs_write", {en, xya}, {1'b1, 7'd4, 6'd3, 7'h20});
    check("bs_cursor", {cursor_x, cursor_y}, {7'd4, 6'd3});
    send(7'h0d, 6'd0, 1'b0);
    next_write(en, xya);
    check("cr_no_write", en, 0);
    check("cr_cursor", {cursor_x, cursor_y}, {7'd0, 6'd3});
    send(7'h07, 6'd0, 1'b0);
    next_write(en, xya);
    check("bel_no_write", en, 0);
    check("bel_cursor", {cursor_x, cursor_y}, {7'd0, 6'd3});
    send(7'h0a, 6'd0, 1'b0);
    wait_ready(w, lo, lxy);
    check("lf_writes", w, 80);
    check("lf_last_xy", lxy, {7'd79, 6'd4});
    check("lf_cursor", {cursor_x, cursor_y}, {7'd0, 6'd4});

    // Mode toggle in the middle of a row clear
    send(7'h0a, 6'd0, 1'b0);
    repeat (10) @(posedge clk);
    #1 sL = 1'b1;
    @(negedge clk);
    wait_ready(w, lo, lxy);
    check("toggle_writes", w, 1200);
    check("toggle_last_xy", lxy, {7'd39, 6'd29});
    check("toggle_cursor", {cursor_x, cursor_y}, 13'd0);

    // Form feed then reset mid-sweep
    sL = 1'b0;
    wait_ready(w, lo, lxy);
    check("small2_writes", w, 4800);
    goto_xy(10, 10);
    check("cursor_10_10", {cursor_x, cursor_y}, {7'd10, 6'd10});
    send(7'h0c, 6'd0, 1'b0);
    w = 0;
    for (int i = 0; i < 500 && w < 100; i++) begin
      @(negedge clk);
      if (wr_en) w++;
    end
    check("ff_pre_reset_writes", w, 100);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_wr_en", wr_en, 0);
    check("reset_cursor", {cursor_x, cursor_y}, 13'd0);
    wait_ready(w, lo, lxy);
    check("reset_sweep_writes", w, 4800);
    check("reset_sweep_last_xy", lxy, {7'd79, 6'd59});

    // Randomized stream against the model
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 1) sL = ~sL;
      else if (r < 2) send(7'h0c, 6'd0, 1'b0);
      else if (r < 8) send(7'h0a, 6'($urandom), 1'($urandom));
      else if (r < 11) send(7'h0d, 6'($urandom), 1'($urandom));
      else if (r < 18) send(7'h08, 6'($urandom), 1'($urandom));
      else if (r < 21) send(7'($urandom_range(0, 31)), 6'($urandom), 1'($urandom));
      else if (r < 22) send(7'h7f, 6'($urandom), 1'($urandom));
      else send(7'($urandom_range(32, 126)), 6'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    wait_ready(w, lo, lxy);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
